ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
Instruction fetch stage sitting directly upstream of the decode unit; owns the PC register and supplies inst/inst_pc to decode over a valid/ready handshake. Issues one outstanding instruction-memory request at a time over a request/response bus, accepts redirects (jump/branch target) from execute, and stops fetching on halt (ebreak) or a fetch fault. Replaces the free-running PC counter feeding decode.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
CNT_W, 32, width of retired-fetch counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets)
mem_req_valid  output  1  fetch request valid
mem_req_ready  input  1  memory accepts request this cycle
mem_req_addr  output  32  fetch address (word-aligned)
mem_resp_valid  input  1  response data valid (one cycle pulse)
mem_resp_data  input  32  fetched instruction word
mem_resp_err  input  1  access fault, qualified by mem_resp_valid
inst_valid  output  1  inst/inst_pc valid to decode
inst_ready  input  1  decode consumes inst this cycle
inst  output  32  instruction to decode
inst_pc  output  32  PC of inst
redirect_valid  input  1  execute redirect strobe
redirect_pc  input  32  redirect target
halt  input  1  ebreak seen by execute
halted  output  1  sticky: fetch stopped
fetch_err  output  1  sticky: fault (resp_err or misaligned redirect)
fetch_cnt  output  CNT_W  number of inst handshakes completed

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=IDLE, mem_req_valid=0, mem_req_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, halted=0, fetch_err=0, fetch_cnt=0, drop=0, halt_pend=0. Reset mid-transaction abandons everything; a late mem_resp_valid after reset in IDLE/REQ is ignored.
- States: IDLE, REQ, WAIT, HOLD, HALT.
- IDLE: one cycle after reset release -> REQ.
- REQ: mem_req_valid=1, mem_req_addr=pc; addr and valid held stable until mem_req_ready=1; on accept -> WAIT.
- WAIT: mem_req_valid=0; on mem_resp_valid: if drop or halt_pend -> discard data, clear drop, go REQ (or HALT if halt_pend); else if mem_resp_err -> fetch_err=1, HALT; else latch inst=mem_resp_data, inst_pc=pc, inst_valid=1, pc=pc+4 -> HOLD.
- HOLD: inst_valid held with stable inst/inst_pc until inst_ready=1; on handshake fetch_cnt+=1, inst_valid=0 -> REQ (next cycle). Minimum fetch latency: request to inst_valid = 1 cycle after response.
- Redirect (redirect_valid=1): redirect_pc[1:0]!=0 -> fetch_err=1, HALT. Otherwise pc=redirect_pc, and: REQ not yet accepted -> request completes at old addr, drop=1 set; REQ accepted same cycle -> WAIT with drop=1; WAIT -> drop=1; HOLD -> inst_valid=0 next cycle, -> REQ. Redirect coincident with inst handshake in HOLD: handshake counts (fetch_cnt+=1), next fetch at redirect_pc. Redirect + response same cycle in WAIT: response discarded.
- Halt: halt sets halt_pend. HOLD/IDLE -> HALT next cycle (inst_valid=0). REQ: finish request, then WAIT, discard response, -> HALT. Halt has priority over redirect.
- HALT: no requests, inst_valid=0, halted=1; exits only by reset.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). fetch_cnt wraps modulo 2^CNT_W.

Test Plan:
- Reset release, mem_req_ready=1, response 1 cycle after accept with data 32'h0010_0093, inst_ready=1 -> first mem_req_addr=32'h8000_0000, inst=32'h0010_0093, inst_pc=32'h8000_0000; next addr 32'h8000_0004, fetch_cnt=1.
- mem_req_ready low 3 cycles -> mem_req_valid and mem_req_addr stable all 3 cycles; inst_ready low 2 cycles in HOLD -> inst/inst_pc stable, fetch_cnt unchanged.
- redirect_valid with redirect_pc=32'h8000_0100 while in WAIT -> pending response discarded (no inst_valid), next request addr 32'h8000_0100.
- redirect_pc=32'h8000_0102 -> fetch_err=1, halted=1, no further mem_req_valid.
- halt in REQ with mem_req_ready=0 -> request held until accept, response dropped, halted=1; mem_resp_err=1 on response -> fetch_err=1, halted=1.
- rst asserted (low) while in WAIT, response arrives during reset and one cycle after -> all outputs at reset values, response ignored, fetch restarts at 32'h8000_0000.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, keeps one memory request in flight at a time,
// and hands inst/inst_pc to decode over a valid/ready handshake.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_mem_req_valid,
  input  logic             i_mem_req_ready,
  output logic [31:0]      o_mem_req_addr,
  input  logic             i_mem_resp_valid,
  input  logic [31:0]      i_mem_resp_data,
  input  logic             i_mem_resp_err,
  output logic             o_inst_valid,
  input  logic             i_inst_ready,
  output logic [31:0]      o_inst,
  output logic [31:0]      o_inst_pc,
  input  logic             i_redirect_valid,
  input  logic [31:0]      i_redirect_pc,
  input  logic             i_halt,
  output logic             o_halted,
  output logic             o_fetch_err,
  output logic [CNT_W-1:0] o_fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_req_addr;
  logic [31:0]      r_inst;
  logic [31:0]      r_inst_pc;
  logic             r_drop;
  logic             r_halt_pend;
  logic             r_fetch_err;
  logic [CNT_W-1:0] r_fetch_cnt;

  state_t      w_state_next;
  logic [31:0] w_pc_next;
  logic        w_drop_next;
  logic        w_halt_pend_next;
  logic        w_err_next;
  logic        w_latch;
  logic        w_halt_req;
  logic        w_redir;
  logic        w_redir_bad;
  logic        w_redir_ok;
  logic        w_hs;

  // A halt (new or pending) masks any redirect arriving alongside or after it.
  assign w_halt_req  = i_halt | r_halt_pend;
  assign w_redir     = i_redirect_valid & ~w_halt_req & (r_state != S_HALT);
  assign w_redir_bad = w_redir & (i_redirect_pc[1:0] != 2'b00);
  assign w_redir_ok  = w_redir & ~w_redir_bad;
  assign w_hs        = (r_state == S_HOLD) & i_inst_ready;

  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_drop_next      = r_drop;
    w_halt_pend_next = r_halt_pend | (i_halt & (r_state != S_HALT));
    w_err_next       = r_fetch_err;
    w_latch          = 1'b0;

    case (r_state)
      S_IDLE: w_state_next = i_halt ? S_HALT : S_REQ;
      S_REQ: begin
        if (i_mem_req_ready) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_mem_resp_valid) begin
          if (r_drop || w_halt_req || w_redir) begin
            w_drop_next  = 1'b0;
            w_state_next = w_halt_req ? S_HALT : S_REQ;
          end else if (i_mem_resp_err) begin
            w_err_next   = 1'b1;
            w_state_next = S_HALT;
          end else begin
            w_latch      = 1'b1;
            w_pc_next    = r_pc + 32'd4;
            w_state_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_halt_req)        w_state_next = S_HALT;
        else if (i_inst_ready) w_state_next = S_REQ;
      end
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_IDLE;
    endcase

    // An in-flight request at the old address must still complete, so it is marked for discard.
    if (w_redir_bad) begin
      w_err_next   = 1'b1;
      w_state_next = S_HALT;
    end else if (w_redir_ok) begin
      w_pc_next = i_redirect_pc;
      if ((r_state == S_REQ) || ((r_state == S_WAIT) && !i_mem_resp_valid)) w_drop_next = 1'b1;
      if (r_state == S_HOLD) w_state_next = S_REQ;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_req_addr  <= RESET_PC;
      r_inst      <= 32'h0;
      r_inst_pc   <= 32'h0;
      r_drop      <= 1'b0;
      r_halt_pend <= 1'b0;
      r_fetch_err <= 1'b0;
      r_fetch_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_drop      <= w_drop_next;
      r_halt_pend <= w_halt_pend_next;
      r_fetch_err <= w_err_next;
      if (w_hs) r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
      if (w_latch) begin
        r_inst    <= i_mem_resp_data;
        r_inst_pc <= r_pc;
      end
      // The request address is frozen on entry to REQ so it stays stable until accepted.
      if ((w_state_next == S_REQ) && (r_state != S_REQ)) r_req_addr <= w_pc_next;
    end
  end

  assign o_mem_req_valid = (r_state == S_REQ);
  assign o_mem_req_addr  = r_req_addr;
  assign o_inst_valid    = (r_state == S_HOLD);
  assign o_inst          = r_inst;
  assign o_inst_pc       = r_inst_pc;
  assign o_halted        = (r_state == S_HALT);
  assign o_fetch_err     = r_fetch_err;
  assign o_fetch_cnt     = r_fetch_cnt;

endmodule
